// File: rtl/aucohl_fifo_wr_arbiter_pkg.sv
// Shared FSM encodings and default constants for the aucohl FIFO write arbiter.
package aucohl_fifo_wr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  localparam int ARB_BURST_DEFAULT = 4;

endpackage

// File: rtl/aucohl_fifo_wr_arbiter_rr_pick.sv
// aucohl_rr_pick: combinational round-robin picker (rotate, isolate lowest set bit, unrotate).
module aucohl_rr_pick #(
  parameter int N  = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  input  logic [N-1:0]  mask,
  output logic          any,
  output logic [LW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [N-1:0]   elig_s;
  logic [2*N-1:0] rot_dbl_s;
  logic [N-1:0]   rot_s;
  logic [N-1:0]   iso_s;
  logic [2*N-1:0] unrot_dbl_s;

  // Bit k of rot_s is requester (last+1+k) mod N, so the lowest set bit is the next in turn.
  assign elig_s      = req & ~mask;
  assign rot_dbl_s   = {elig_s, elig_s} >> (int'(last) + 1);
  assign rot_s       = rot_dbl_s[N-1:0];
  assign iso_s       = rot_s & (~rot_s + {{(N-1){1'b0}}, 1'b1});
  assign unrot_dbl_s = {iso_s, iso_s} << (int'(last) + 1);
  assign onehot      = unrot_dbl_s[2*N-1:N];
  assign any         = |elig_s;

  // Encode the one-hot winner into an index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = idx | (onehot[i] ? LW'(i) : {LW{1'b0}});
    end
  end

endmodule

// File: rtl/aucohl_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one aucohl_fifo write port among N valid/ready requesters.
// Define AUCOHL_ARB_BURST_EN to allow up to BURST beats per grant; otherwise one beat per grant.
module aucohl_fifo_wr_arbiter
  import aucohl_fifo_wr_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int BURST = ARB_BURST_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            fifo_full,
  output logic            fifo_wr,
  output logic [DW-1:0]   fifo_wdata,
  output logic [N-1:0]    grant
);

  localparam int LW = $clog2(N);

  arb_state_e    state_r;
  logic [N-1:0]  grant_r;
  logic [LW-1:0] owner_r;
  logic [LW-1:0] rr_last_r;

  logic          own_s;
  logic          owner_valid_s;
  logic          beat_s;
  logic          limit_s;
  logic          release_s;
  logic [LW-1:0] pick_last_s;
  logic [N-1:0]  pick_mask_s;
  logic          pick_any_s;
  logic [LW-1:0] pick_idx_s;
  logic [N-1:0]  pick_onehot_s;

  assign own_s         = (state_r == ARB_OWN);
  assign owner_valid_s = req_valid[owner_r];
  assign beat_s        = own_s & owner_valid_s & ~fifo_full;
  assign release_s     = own_s & (~owner_valid_s | (beat_s & limit_s));

  // While owning, the re-pick starts after the owner and excludes it; from IDLE it uses rr_last.
  assign pick_last_s = own_s ? owner_r : rr_last_r;
  assign pick_mask_s = own_s ? grant_r : {N{1'b0}};

  aucohl_rr_pick #(
    .N  (N),
    .LW (LW)
  ) u_pick (
    .req    (req_valid),
    .last   (pick_last_s),
    .mask   (pick_mask_s),
    .any    (pick_any_s),
    .idx    (pick_idx_s),
    .onehot (pick_onehot_s)
  );

`ifdef AUCOHL_ARB_BURST_EN
  localparam logic [7:0] BURST_LIM = 8'(BURST);
  logic [7:0] beat_cnt_r;

  assign limit_s = ({1'b0, beat_cnt_r} + 9'd1) >= {1'b0, BURST_LIM};

  // Beats taken by the current owner; cleared between grants, saturating at BURST.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r <= 8'd0;
    end else if (!own_s || release_s) begin
      beat_cnt_r <= 8'd0;
    end else if (beat_s && (beat_cnt_r != BURST_LIM)) begin
      beat_cnt_r <= beat_cnt_r + 8'd1;
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end
`else
  logic unused_burst_s;

  assign limit_s        = 1'b1;
  assign unused_burst_s = ^8'(BURST);
`endif

  // Grant FSM: IDLE arbitrates with one cycle latency, OWN hands off directly on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ARB_IDLE;
      grant_r   <= {N{1'b0}};
      owner_r   <= {LW{1'b0}};
      rr_last_r <= LW'(N - 1);
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (en && pick_any_s) begin
            state_r <= ARB_OWN;
            grant_r <= pick_onehot_s;
            owner_r <= pick_idx_s;
          end else begin
            state_r <= ARB_IDLE;
            grant_r <= {N{1'b0}};
          end
        end
        ARB_OWN: begin
          if (release_s) begin
            rr_last_r <= owner_r;
            if (en && pick_any_s) begin
              state_r <= ARB_OWN;
              grant_r <= pick_onehot_s;
              owner_r <= pick_idx_s;
            end else begin
              state_r <= ARB_IDLE;
              grant_r <= {N{1'b0}};
            end
          end else begin
            state_r <= ARB_OWN;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
          grant_r <= {N{1'b0}};
        end
      endcase
    end
  end

  assign grant      = grant_r;
  assign req_ready  = grant_r & {N{~fifo_full}};
  assign fifo_wr    = beat_s;
  assign fifo_wdata = req_data[int'(owner_r)*DW +: DW];

endmodule

// File: tb/tb_aucohl_fifo_wr_arbiter.sv
// Self-checking bench for aucohl_fifo_wr_arbiter against an integer-level model of the grant rules.
module tb_aucohl_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;
`ifdef AUCOHL_ARB_BURST_EN
  localparam int LIM = BURST;
`else
  localparam int LIM = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_wdata;
  logic [N-1:0]    grant;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: owner (-1 = none), last served requester, beats in current grant.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_beats = 0;

  always #5 clk = ~clk;

  aucohl_fifo_wr_arbiter #(.N(N), .DW(DW), .BURST(BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .grant      (grant)
  );

  function automatic int pick(input logic [N-1:0] v, input int last, input int excl);
    for (int k = 1; k <= N; k++) begin
      int r = (last + k) % N;
      if (v[r] && r != excl) return r;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    return (m_owner < 0) ? {N{1'b0}} : (N'(1) << m_owner);
  endfunction

  function automatic logic exp_wr();
    return (m_owner >= 0) && req_valid[m_owner] && !fifo_full;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    return (m_owner >= 0 && !fifo_full) ? exp_grant() : {N{1'b0}};
  endfunction

  function automatic logic [DW-1:0] exp_data();
    return (m_owner >= 0) ? req_data[m_owner*DW +: DW] : {DW{1'b0}};
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_beats = 0;
    end else if (m_owner < 0) begin
      int p = en ? pick(req_valid, m_last, -1) : -1;
      if (p >= 0) begin m_owner = p; m_beats = 0; end
    end else begin
      logic b = exp_wr();
      logic rel;
      if (b) m_beats++;
      rel = !req_valid[m_owner] || (b && m_beats >= LIM);
      if (rel) begin
        m_last  = m_owner;
        m_owner = en ? pick(req_valid, m_owner, m_owner) : -1;
        m_beats = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; fifo_full = 1'b0; req_valid = 4'b1111; req_data = 32'h33221100;
    tick(); tick();
    vectors++;
    if (grant !== 4'b0000 || fifo_wr !== 1'b0 || req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_state grant=%b wr=%b ready=%b required 0000/0/0000", grant, fifo_wr, req_ready);
    end
    rst = 1'b0;
    tick(); #1;
    vectors++;
    if (grant !== 4'b0001 || fifo_wr !== 1'b1 || fifo_wdata !== 8'h00) begin
      miscompares++;
      $display("FAIL first_grant grant=%b wr=%b data=%h required 0001/1/00", grant, fifo_wr, fifo_wdata);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    req_valid = 4'b1111; req_data = 32'h33221100;
    for (int c = 0; c <= 8; c++) begin
      #1;
      vectors++;
      if (grant !== exp_grant() || fifo_wr !== exp_wr() || req_ready !== exp_ready()) begin
        miscompares++;
        $display("FAIL fair_model c=%0d grant=%b/%b wr=%b/%b ready=%b/%b", c, grant, exp_grant(), fifo_wr, exp_wr(), req_ready, exp_ready());
      end
      if (c >= 1) begin
        logic [N-1:0] g = N'(1) << (((c - 1) / LIM) % N);
        vectors++;
        if (grant !== g || fifo_wr !== 1'b1 || fifo_wdata !== req_data[(((c - 1) / LIM) % N)*DW +: DW]) begin
          miscompares++;
          $display("FAIL fair_order c=%0d grant=%b wr=%b data=%h required %b/1", c, grant, fifo_wr, fifo_wdata, g);
        end
      end
      tick();
    end
  endtask

  task automatic test_handoff();
    do_reset();
    req_valid = 4'b0101; req_data = 32'h44332211;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) req_valid = 4'b0100;
      #1;
      vectors++;
      if (grant !== exp_grant() || fifo_wr !== exp_wr() || (exp_wr() && fifo_wdata !== exp_data())) begin
        miscompares++;
        $display("FAIL handoff_model c=%0d grant=%b/%b wr=%b/%b data=%h/%h", c, grant, exp_grant(), fifo_wr, exp_wr(), fifo_wdata, exp_data());
      end
      if (c == 3 || c == 4) begin
        vectors++;
        if (grant !== ((c == 3) ? 4'b0001 : 4'b0100) || fifo_wr !== (c == 4)) begin
          miscompares++;
          $display("FAIL handoff_direct c=%0d grant=%b wr=%b", c, grant, fifo_wr);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    logic [DW-1:0] nxt;
    do_reset();
    d = 8'hA0; nxt = 8'hA0;
    req_valid = 4'b0010; req_data = '0; req_data[DW +: DW] = d;
    tick();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (grant !== 4'b0010 || fifo_wr !== 1'b0 || req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL full_stall c=%0d grant=%b wr=%b ready=%b required 0010/0/0000", c, grant, fifo_wr, req_ready);
      end
      tick();
    end
    fifo_full = 1'b0;
    for (int c = 0; c < 8; c++) begin
      logic hs;
      req_data[DW +: DW] = d;
      #1;
      vectors++;
      if (grant !== exp_grant() || fifo_wr !== exp_wr() || req_ready !== exp_ready()) begin
        miscompares++;
        $display("FAIL bp_model c=%0d grant=%b/%b wr=%b/%b", c, grant, exp_grant(), fifo_wr, exp_wr());
      end
      if (fifo_wr) begin
        vectors++;
        if (fifo_wdata !== nxt) begin
          miscompares++;
          $display("FAIL bp_data c=%0d data=%h required %h", c, fifo_wdata, nxt);
        end
        nxt = nxt + 8'd1;
      end
      hs = req_valid[1] & req_ready[1];
      tick();
      if (hs) d = d + 8'd1;
    end
    vectors++;
    if (nxt == 8'hA0) begin
      miscompares++;
      $display("FAIL bp_resume no beat after full cleared, required at least one");
    end
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0; req_valid = 4'b0100; req_data = 32'h0055AA00;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (grant !== 4'b0000 || fifo_wr !== 1'b0) begin
        miscompares++;
        $display("FAIL en_idle c=%0d grant=%b wr=%b required 0000/0", c, grant, fifo_wr);
      end
    end
    en = 1'b1; req_valid = 4'b0010;
    tick();
    en = 1'b0; req_valid = 4'b0110;
    for (int c = 0; c < 8; c++) begin
      #1;
      vectors++;
      if (grant !== exp_grant() || fifo_wr !== exp_wr() || (exp_wr() && fifo_wdata !== exp_data())) begin
        miscompares++;
        $display("FAIL en_model c=%0d grant=%b/%b wr=%b/%b", c, grant, exp_grant(), fifo_wr, exp_wr());
      end
      if (c == 0) begin
        vectors++;
        if (grant !== 4'b0010 || fifo_wr !== 1'b1 || fifo_wdata !== 8'hAA) begin
          miscompares++;
          $display("FAIL en_own grant=%b wr=%b data=%h required 0010/1/aa", grant, fifo_wr, fifo_wdata);
        end
      end
      tick();
    end
    vectors++;
    if (grant !== 4'b0000 || fifo_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL en_release grant=%b wr=%b required 0000/0", grant, fifo_wr);
    end
    en = 1'b1;
  endtask

  task automatic test_random_scoreboard();
    int cnt[N];
    int exp_seq[N];
    int wait_b[N];
    logic [N-1:0] hs;
    do_reset();
    req_valid = '0;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; exp_seq[i] = 0; wait_b[i] = 0; end
    hs = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hs[i]) cnt[i]++;
        if (hs[i] || !req_valid[i]) req_valid[i] = 1'($urandom_range(0, 1));
        req_data[i*DW +: DW] = {2'(i), 6'(cnt[i])};
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      #1;
      vectors++;
      if (grant !== exp_grant() || fifo_wr !== exp_wr() || req_ready !== exp_ready()) begin
        miscompares++;
        $display("FAIL rand_model c=%0d grant=%b/%b wr=%b/%b ready=%b/%b", c, grant, exp_grant(), fifo_wr, exp_wr(), req_ready, exp_ready());
      end
      if (fifo_wr) begin
        int id = int'(fifo_wdata[7:6]);
        vectors++;
        if (fifo_full || fifo_wdata[5:0] !== 6'(exp_seq[id])) begin
          miscompares++;
          $display("FAIL rand_seq c=%0d id=%0d seq=%0d full=%b required seq %0d not full", c, id, fifo_wdata[5:0], fifo_full, exp_seq[id] % 64);
        end
        exp_seq[id]++;
        for (int i = 0; i < N; i++) begin
          if (i == id) wait_b[i] = 0;
          else if (req_valid[i]) wait_b[i]++;
        end
        vectors++;
        if (wait_b[0] > (N-1)*LIM || wait_b[1] > (N-1)*LIM || wait_b[2] > (N-1)*LIM || wait_b[3] > (N-1)*LIM) begin
          miscompares++;
          $display("FAIL rand_starve c=%0d waits=%0d,%0d,%0d,%0d limit %0d", c, wait_b[0], wait_b[1], wait_b[2], wait_b[3], (N-1)*LIM);
        end
      end
      hs = req_valid & req_ready;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_handoff();
    test_backpressure();
    test_enable();
    test_random_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
